// File: rtl/mem_pkg.sv
// Shared constants and read-pipe entry type for the 4-bank interleaved main memory.
package mem_pkg;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = 13;
  localparam int BANK_BUSY = 4;
  localparam int NUM_BANKS = 4;
  localparam int BANK_LSB  = 1;
  localparam int BANK_MSB  = 2;
  localparam int IDX_LSB   = 3;
  localparam int BANK_W    = BANK_MSB - BANK_LSB + 1;

  typedef struct packed {
    logic              valid;
    logic [BANK_W-1:0] bank;
    logic [DATA_W-1:0] data;
  } rd_pipe_t;
endpackage

// File: rtl/mem_bank.sv
// One memory bank: word storage plus the busy down-counter that spaces accepted requests.
module mem_bank
  import mem_pkg::*;
#(
  parameter int BANK_DATA_W = DATA_W,
  parameter int BANK_IDX_W  = IDX_W,
  parameter int BUSY_CYC    = BANK_BUSY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  input  logic                   we,
  input  logic                   re,
  input  logic [BANK_IDX_W-1:0]  idx,
  input  logic [BANK_DATA_W-1:0] din,
  output logic [BANK_DATA_W-1:0] dout,
  output logic                   busy
);
  localparam int CNT_W = $clog2(BUSY_CYC);

  logic [BANK_DATA_W-1:0] mem [2**BANK_IDX_W];
  logic [CNT_W-1:0]       cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sel) begin
      cnt <= CNT_W'(BUSY_CYC - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM; rst only affects control state.
  always_ff @(posedge clk) begin
    if (sel && we) begin
      mem[idx] <= din;
    end
  end

  assign dout = (sel && re) ? mem[idx] : '0;
  assign busy = (cnt != '0);
endmodule

// File: rtl/banked_main_mem.sv
// 4-bank interleaved main memory responder with a fixed 2-cycle read latency.
// Optional MEM_DUMP_EN: simulation-only dump of nonzero words on createdump.
module banked_main_mem
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              createdump,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic              err
);
  logic                 req;
  logic                 accept;
  logic [BANK_W-1:0]    bank_sel;
  logic [IDX_W-1:0]     idx;
  logic [NUM_BANKS-1:0] bank_en;
  logic [DATA_W-1:0]    bank_dout [NUM_BANKS];
  rd_pipe_t             s1_q;
  rd_pipe_t             s2_q;

  assign req      = rd | wr;
  assign bank_sel = addr[BANK_MSB:BANK_LSB];
  assign idx      = addr[IDX_LSB +: IDX_W];

  // Error outranks stall; nothing is accepted while rst is high.
  assign err    = ~rst & req & (addr[0] | (rd & wr));
  assign stall  = ~rst & req & ~err & busy[bank_sel];
  assign accept = ~rst & req & ~err & ~busy[bank_sel];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = accept & (bank_sel == BANK_W'(b));

    mem_bank u_bank (
      .clk  (clk),
      .rst  (rst),
      .sel  (bank_en[b]),
      .we   (wr),
      .re   (rd),
      .idx  (idx),
      .din  (data_in),
      .dout (bank_dout[b]),
      .busy (busy[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= '{valid: accept & rd, bank: bank_sel, data: bank_dout[bank_sel]};
      s2_q <= s1_q;
    end
  end

  assign data_out = s2_q.valid ? s2_q.data : '0;

  // The bank tag travels with the entry for debug visibility only.
  logic unused_bank;
  assign unused_bank = ^s2_q.bank;

`ifdef MEM_DUMP_EN
  logic              dump_q;
  logic [DATA_W-1:0] dump_word;

  always_ff @(posedge clk) begin
    dump_q <= createdump;
  end

  // Walk index-major, bank-minor so the dump comes out in ascending byte address.
  always @(posedge clk) begin
    if (createdump && !dump_q) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          case (b)
            0:       dump_word = g_bank[0].u_bank.mem[i];
            1:       dump_word = g_bank[1].u_bank.mem[i];
            2:       dump_word = g_bank[2].u_bank.mem[i];
            default: dump_word = g_bank[3].u_bank.mem[i];
          endcase
          if (dump_word != '0) begin
            $display("%h %h", ADDR_W'((i << IDX_LSB) | (b << BANK_LSB)), dump_word);
          end
        end
      end
    end
  end
`else
  logic unused_createdump;
  assign unused_createdump = createdump;
`endif
endmodule

// File: tb/tb_banked_main_mem.sv
// Self-checking bench for banked_main_mem: directed vector table, reset-mid-read sequence, random vs model.
module tb_banked_main_mem;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        createdump;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  always #5 clk = ~clk;

  banked_main_mem dut (
    .clk        (clk),
    .rst        (rst),
    .createdump (createdump),
    .addr       (addr),
    .data_in    (data_in),
    .wr         (wr),
    .rd         (rd),
    .data_out   (data_out),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_err;
    logic        e_stall;
    logic [3:0]  e_busy;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: when each bank frees up, reads due per cycle, and memory contents.
  int          free_at [4];
  logic [15:0] exp_rd [int];
  logic [15:0] mem_m [int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic vec_t v(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic ee, input logic es, input logic [3:0] eb, input logic [15:0] ed);
    vec_t t;
    t.r = r; t.w = w; t.a = a; t.d = d;
    t.e_err = ee; t.e_stall = es; t.e_busy = eb; t.e_dout = ed;
    return t;
  endfunction

  task automatic model_cycle(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic        req;
    logic        e;
    logic        s;
    int          b;
    logic [3:0]  eb;
    logic [15:0] ed;
    drive(r, w, a, d);
    req = r | w;
    e   = req && (a[0] || (r && w));
    b   = int'(a[2:1]);
    for (int k = 0; k < 4; k++) eb[k] = (cyc < free_at[k]);
    s   = req && !e && eb[b];
    ed  = exp_rd.exists(cyc) ? exp_rd[cyc] : 16'h0000;
    @(negedge clk);
    check("rnd_err", 32'(err), 32'(e));
    check("rnd_stall", 32'(stall), 32'(s));
    check("rnd_busy", 32'(busy), 32'(eb));
    check("rnd_dout", 32'(data_out), 32'(ed));
    if (req && !e && !s) begin
      free_at[b] = cyc + BANK_BUSY;
      if (w) mem_m[int'(a)] = d;
      else   exp_rd[cyc + 2] = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 16'h0000;
    end
    exp_rd.delete(cyc);
    next_cycle();
  endtask

  initial begin
    rst        = 1'b1;
    createdump = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);

    // Cycle-by-cycle script with hand-derived expectations.
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'hBEEF));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0100, 16'h1111, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0102, 16'h2222, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0104, 16'h3333, 0, 0, 4'b0011, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0106, 16'h4444, 0, 0, 4'b0111, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1110, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0100, 16'h0000, 0, 0, 4'b1100, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0102, 16'h0000, 0, 0, 4'b1001, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0104, 16'h0000, 0, 0, 4'b0011, 16'h1111));
    vecs.push_back(v(1, 0, 16'h0106, 16'h0000, 0, 0, 4'b0111, 16'h2222));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1110, 16'h3333));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1100, 16'h4444));
    vecs.push_back(v(0, 1, 16'h0208, 16'h7777, 0, 0, 4'b1000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0200, 16'h5A5A, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0208, 16'h0000, 0, 1, 4'b0001, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0208, 16'h0000, 0, 1, 4'b0001, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0208, 16'h0000, 0, 1, 4'b0001, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0208, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h7777));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0001, 16'h0000, 1, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(1, 1, 16'h0100, 16'hDEAD, 1, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0100, 16'h0000, 0, 0, 4'b0000, 16'h0000));
    vecs.push_back(v(0, 1, 16'h0101, 16'hFFFF, 1, 0, 4'b0001, 16'h0000));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h1111));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 16'h0000));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
      @(negedge clk);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].e_dout));
      next_cycle();
    end

    // Reset arriving one cycle after a read is accepted must drop that read.
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check("rstrd_accept_stall", 32'(stall), 32'(1'b0));
    check("rstrd_accept_busy", 32'(busy), 32'(4'b0000));
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_during_busy", 32'(busy), 32'(4'b0001));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstrd_t2_dout", 32'(data_out), 32'(16'h0000));
    check("rstrd_t2_busy", 32'(busy), 32'(4'b0000));
    next_cycle();
    @(negedge clk);
    check("rstrd_t3_dout", 32'(data_out), 32'(16'h0000));
    next_cycle();

    // Random traffic against the model over a small pool of words in every bank.
    for (int k = 0; k < 4; k++) free_at[k] = 0;
    for (int w = 0; w < 16; w++) begin
      model_cycle(1'b0, 1'b1, {13'(16'h0500 + (w / 4)), 2'(w % 4), 1'b0}, 16'($urandom));
    end
    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [15:0] a;
      sel = int'($urandom_range(0, 9));
      a   = {13'(16'h0500 + $urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 15) == 0)};
      if (sel == 0)      model_cycle(1'b0, 1'b0, a, 16'h0000);
      else if (sel == 1) model_cycle(1'b1, 1'b1, a, 16'($urandom));
      else if (sel < 6)  model_cycle(1'b1, 1'b0, a, 16'h0000);
      else               model_cycle(1'b0, 1'b1, a, 16'($urandom));
    end
    for (int n = 0; n < 4; n++) model_cycle(1'b0, 1'b0, 16'h0000, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
